// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encodings and helpers for the iterative cipher.
package aes_pkg;

    localparam int unsigned NR       = 10;
    localparam int unsigned BLOCK_W  = 128;
    localparam int unsigned RK_BUS_W = 1280;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    // Round key i (1..NR) from the packed schedule bus; rk1 sits in the top slot.
    function automatic logic [BLOCK_W-1:0] rk_sel(input logic [RK_BUS_W-1:0] bus,
                                                  input logic [CNT_W-1:0]    idx);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            if (idx == CNT_W'(i)) begin
                r = bus[RK_BUS_W-1-BLOCK_W*(i-1) -: BLOCK_W];
            end
        end
        return r;
    endfunction

    // GF(2^8) multiply-by-2, reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Start/finish pulse handshake and data bus between the controller and the cipher core.
interface aes_cipher_iter_if;
    import aes_pkg::*;

    logic                start;
    logic [BLOCK_W-1:0]  key;
    logic [RK_BUS_W-1:0] roundkeys;
    logic [BLOCK_W-1:0]  plaintext;
    logic [BLOCK_W-1:0]  ciphertext;
    logic                busy;
    logic                finish;

    modport master (
        output start, key, roundkeys, plaintext,
        input  ciphertext, busy, finish
    );

    modport slave (
        input  start, key, roundkeys, plaintext,
        output ciphertext, busy, finish
    );

endinterface

// File: rtl/STable.sv
// AES forward S-box lookup (FIPS-197 Fig. 7), byte in / byte out.
module STable (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s_o = SBOX[11'(2047) - {a_i, 3'b000} -: 8];

endmodule

// File: rtl/aes_round.sv
// One combinational AES round; final_i drops MixColumns for the last round.
module aes_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] in_i,
    input  logic [BLOCK_W-1:0] rk_i,
    input  logic               final_i,
    output logic [BLOCK_W-1:0] out_o
);

    logic [BLOCK_W-1:0] sub_w;
    logic [BLOCK_W-1:0] shr_w;
    logic [BLOCK_W-1:0] mix_w;

    // Byte n is row n%4 of column n/4; ShiftRows rotates row r left by r columns.
    for (genvar n = 0; n < 16; n++) begin : g_byte
        localparam int unsigned SRC = 4 * (((n / 4) + (n % 4)) % 4) + (n % 4);

        STable u_sbox (
            .a_i (in_i[BLOCK_W-1-8*n -: 8]),
            .s_o (sub_w[BLOCK_W-1-8*n -: 8])
        );

        assign shr_w[BLOCK_W-1-8*n -: 8] = sub_w[BLOCK_W-1-8*SRC -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;

        assign a0 = shr_w[BLOCK_W-1-32*c  -: 8];
        assign a1 = shr_w[BLOCK_W-9-32*c  -: 8];
        assign a2 = shr_w[BLOCK_W-17-32*c -: 8];
        assign a3 = shr_w[BLOCK_W-25-32*c -: 8];

        assign mix_w[BLOCK_W-1-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

    assign out_o = (final_i ? shr_w : mix_w) ^ rk_i;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor: initial AddRoundKey on start, then one round per clock.
module aes_cipher_iter
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    aes_cipher_iter_if.slave cif
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [BLOCK_W-1:0] data_q;
    logic [BLOCK_W-1:0] data_d;
    logic [BLOCK_W-1:0] ct_q;
    logic [BLOCK_W-1:0] ct_d;
    logic               busy_q;
    logic               busy_d;
    logic               fin_q;
    logic               fin_d;

    logic [BLOCK_W-1:0] rk_w;
    logic [BLOCK_W-1:0] round_w;
    logic               last_w;

    assign rk_w   = rk_sel(cif.roundkeys, cnt_q);
    assign last_w = (cnt_q == CNT_W'(NR));

    aes_round u_round (
        .in_i    (data_q),
        .rk_i    (rk_w),
        .final_i (last_w),
        .out_o   (round_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ct_q    <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ct_q    <= ct_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    // Next state and datapath; start outside S_IDLE is simply not looked at.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ct_d    = ct_q;
        case (state_q)
            S_IDLE: begin
                if (cif.start) begin
                    data_d  = cif.plaintext ^ cif.key;
                    cnt_d   = CNT_W'(1);
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                data_d = round_w;
                if (last_w) begin
                    ct_d    = round_w;
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they register alongside it.
    always_comb begin
        busy_d = 1'b0;
        fin_d  = 1'b0;
        case (state_d)
            S_ROUND: busy_d = 1'b1;
            S_FIN:   fin_d  = 1'b1;
            default: ;
        endcase
    end

    assign cif.ciphertext = ct_q;
    assign cif.busy       = busy_q;
    assign cif.finish     = fin_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed FIPS-197 / SP 800-38A vectors against the iterative AES-128 core.
module tb_aes_cipher_iter;

    localparam int unsigned WIN = 20;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [1279:0] RK_B = {
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [127:0] PT_S  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_S  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [1279:0] RK_C = {
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_cipher_iter_if cif ();

    aes_cipher_iter dut (
        .clk (clk),
        .rst (rst),
        .cif (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One block over a fixed window; cycle 1 is the one opened by the start edge.
    // mask[c] re-pulses start so that it is sampled on edge c of the operation.
    task automatic run_block(input string tag, input logic [127:0] k, input logic [1279:0] rks,
                             input logic [127:0] pt, input logic [127:0] exp_ct,
                             input logic [31:0] mask, input bit chk_hold,
                             input logic [127:0] hold_ct);
        int           fin_cnt;
        int           fin_cycle;
        int           busy_cnt;
        int           held;
        logic [127:0] ct_at_fin;
        fin_cnt   = 0;
        fin_cycle = -1;
        busy_cnt  = 0;
        held      = 1;
        ct_at_fin = '0;
        cif.key       = k;
        cif.roundkeys = rks;
        cif.plaintext = pt;
        cif.start     = 1'b1;
        cycle();
        cif.start     = 1'b0;
        cif.key       = ~k;
        cif.plaintext = ~pt;
        for (int i = 0; i < int'(WIN); i++) begin
            if (cif.busy) busy_cnt++;
            if (cif.finish) begin
                fin_cnt++;
                if (fin_cycle < 0) begin
                    fin_cycle = i + 1;
                    ct_at_fin = cif.ciphertext;
                end
            end else if (fin_cnt == 0 && chk_hold && cif.ciphertext !== hold_ct) begin
                held = 0;
            end
            cif.start = mask[i+1];
            cycle();
        end
        cif.start = 1'b0;
        check_vec({tag, "_ct_at_finish"}, ct_at_fin, exp_ct);
        check_int({tag, "_finish_cycle"}, fin_cycle, 11);
        check_int({tag, "_finish_pulses"}, fin_cnt, 1);
        check_int({tag, "_busy_cycles"}, busy_cnt, 10);
        check_vec({tag, "_ct_after"}, cif.ciphertext, exp_ct);
        if (chk_hold) check_int({tag, "_prev_ct_held"}, held, 1);
    endtask

    initial begin
        int fin_seen;
        int busy_seen;
        int ct_changes;
        logic [127:0] ct_ref;

        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        cif.start     = 1'b0;
        cif.key       = '0;
        cif.roundkeys = '0;
        cif.plaintext = '0;

        cycle();
        cycle();
        check_vec("reset_ct", cif.ciphertext, '0);
        check_int("reset_busy", int'(cif.busy), 0);
        check_int("reset_finish", int'(cif.finish), 0);
        rst = 1'b0;
        cycle();
        check_int("idle_busy", int'(cif.busy), 0);

        run_block("appB", KEY_B, RK_B, PT_B, CT_B, 32'd0, 1'b0, '0);
        run_block("appC1", KEY_C, RK_C, PT_C, CT_C, 32'd0, 1'b0, '0);

        // Start re-asserted mid-round (cycles 3, 10) and during the finish cycle (11).
        run_block("restart_ign", KEY_B, RK_B, PT_B, CT_B,
                  (32'd1 << 3) | (32'd1 << 10) | (32'd1 << 11), 1'b0, '0);

        run_block("seq1", KEY_B, RK_B, PT_B, CT_B, 32'd0, 1'b0, '0);
        run_block("seq2", KEY_B, RK_B, PT_S, CT_S, 32'd0, 1'b1, CT_B);

        // Abort with reset while round 5 is about to execute.
        cif.key       = KEY_B;
        cif.roundkeys = RK_B;
        cif.plaintext = PT_B;
        cif.start     = 1'b1;
        cycle();
        cif.start = 1'b0;
        repeat (4) cycle();
        check_int("pre_abort_busy", int'(cif.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check_vec("abort_ct", cif.ciphertext, '0);
        check_int("abort_busy", int'(cif.busy), 0);
        check_int("abort_finish", int'(cif.finish), 0);
        cycle();
        rst = 1'b0;
        fin_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (cif.finish) fin_seen++;
            if (cif.busy) busy_seen++;
            cycle();
        end
        check_int("abort_no_finish", fin_seen, 0);
        check_int("abort_stays_idle", busy_seen, 0);

        run_block("post_abort", KEY_B, RK_B, PT_B, CT_B, 32'd0, 1'b0, '0);

        // Idle hold with nothing started.
        fin_seen   = 0;
        ct_changes = 0;
        ct_ref     = CT_B;
        for (int i = 0; i < 50; i++) begin
            if (cif.finish) fin_seen++;
            if (cif.ciphertext !== ct_ref) ct_changes++;
            cycle();
        end
        check_int("idle_finish_quiet", fin_seen, 0);
        check_int("idle_ct_changes", ct_changes, 0);
        check_vec("idle_ct", cif.ciphertext, CT_B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
